// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit, control unit and datapath operand muxes.
package hazard_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_ALU   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } optype_e;

  typedef enum logic [1:0] {
    FWD_RF       = 2'd0,
    FWD_EX_ALU   = 2'd1,
    FWD_MEM_ALU  = 2'd2,
    FWD_MEM_LOAD = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    optype_e    optype;
    logic [4:0] rd;
    logic [4:0] rs2;
  } stage_t;

  localparam int unsigned STAGE_W = $bits(stage_t);

  // Only ALU and LOAD producers write a register; x0 never carries a dependency.
  function automatic logic reg_match(input logic src_use, input logic [4:0] src_idx,
                                     input stage_t stg);
    return src_use && (src_idx != 5'd0) && (src_idx == stg.rd) &&
           ((stg.optype == OP_ALU) || (stg.optype == OP_LOAD));
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline tracking stage: async clear, bubble load on stall, else capture.
import hazard_pkg::*;

module hazard_stage_reg (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   bubble_i,
  input  stage_t d_i,
  output stage_t q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        q_o <= '0;
    else if (bubble_i) q_o <= '0;
    else               q_o <= d_i;
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall detection, operand forwarding select and IF/ID/EX pipeline control.
import hazard_pkg::*;

module hazard_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs1use,
  input  logic       rs2use,
  input  logic [1:0] hazard_optype,
  input  logic [4:0] rd_ctrl,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       Branch_ctrl,
  output logic       PC_EN_IF,
  output logic       reg_FD_EN,
  output logic       reg_FD_flush,
  output logic       reg_DE_flush,
  output logic [1:0] forward_ctrl_A,
  output logic [1:0] forward_ctrl_B,
  output logic       forward_ctrl_ls
);

  optype_e  id_op;
  stage_t   id_d;
  stage_t   ex_q;
  stage_t   mem_q;
  logic     stall;
  logic     m1_ex, m2_ex, m1_mem, m2_mem;
  fwd_sel_e fwd_a, fwd_b;
  logic     mem_rs2_unused;

  assign id_op = optype_e'(hazard_optype);
  assign id_d  = '{optype: id_op, rd: rd_ctrl, rs2: rs2_addr};

  hazard_stage_reg u_ex (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (stall),
    .d_i      (id_d),
    .q_o      (ex_q)
  );

  hazard_stage_reg u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  assign mem_rs2_unused = ^mem_q.rs2;

  assign m1_ex  = reg_match(rs1use, rs1_addr, ex_q);
  assign m2_ex  = reg_match(rs2use, rs2_addr, ex_q);
  assign m1_mem = reg_match(rs1use, rs1_addr, mem_q);
  assign m2_mem = reg_match(rs2use, rs2_addr, mem_q);

  // A store's rs2 against an EX load is not stalled: forward_ctrl_ls covers it next cycle.
  assign stall = (ex_q.optype == OP_LOAD) &&
                 (m1_ex || (m2_ex && (id_op != OP_STORE)));

  always_comb begin
    fwd_a = FWD_RF;
    if (m1_ex && ex_q.optype == OP_ALU)          fwd_a = FWD_EX_ALU;
    else if (m1_mem && mem_q.optype == OP_ALU)   fwd_a = FWD_MEM_ALU;
    else if (m1_mem && mem_q.optype == OP_LOAD)  fwd_a = FWD_MEM_LOAD;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (m2_ex && ex_q.optype == OP_ALU)          fwd_b = FWD_EX_ALU;
    else if (m2_mem && mem_q.optype == OP_ALU)   fwd_b = FWD_MEM_ALU;
    else if (m2_mem && mem_q.optype == OP_LOAD)  fwd_b = FWD_MEM_LOAD;
  end

  assign forward_ctrl_A  = fwd_a;
  assign forward_ctrl_B  = fwd_b;
  assign forward_ctrl_ls = (ex_q.optype == OP_STORE) && (mem_q.optype == OP_LOAD) &&
                           (mem_q.rd == ex_q.rs2) && (ex_q.rs2 != 5'd0);

  assign PC_EN_IF     = !stall;
  assign reg_FD_EN    = !stall;
  assign reg_DE_flush = stall;
  assign reg_FD_flush = !stall && Branch_ctrl;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rs1use, rs2use;
  logic [1:0] hazard_optype;
  logic [4:0] rd_ctrl, rs1_addr, rs2_addr;
  logic       Branch_ctrl;
  logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic       forward_ctrl_ls;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [1:0] NONE = 2'd0, ALU = 2'd1, LOAD = 2'd2, STORE = 2'd3;

  hazard_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1use          (rs1use),
    .rs2use          (rs2use),
    .hazard_optype   (hazard_optype),
    .rd_ctrl         (rd_ctrl),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .Branch_ctrl     (Branch_ctrl),
    .PC_EN_IF        (PC_EN_IF),
    .reg_FD_EN       (reg_FD_EN),
    .reg_FD_flush    (reg_FD_flush),
    .reg_DE_flush    (reg_DE_flush),
    .forward_ctrl_A  (forward_ctrl_A),
    .forward_ctrl_B  (forward_ctrl_B),
    .forward_ctrl_ls (forward_ctrl_ls)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic u1, input logic u2, input logic [1:0] op,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    rs1use = u1; rs2use = u2; hazard_optype = op;
    rd_ctrl = rd; rs1_addr = r1; rs2_addr = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, fwdA, fwdB, ls} for one-shot checks.
  function automatic logic [15:0] ctl();
    return {7'd0, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
            forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};
  endfunction

  localparam logic [15:0] CTL_IDLE  = 16'b0000000_1100_00_00_0;
  localparam logic [15:0] CTL_STALL = 16'b0000000_0001_00_00_0;

  task automatic flush2();
    set_id(0, 0, NONE, 0, 0, 0);
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; Branch_ctrl = 1'b0;
    set_id(0, 0, NONE, 0, 0, 0);
    #2;
    check("reset_idle", ctl(), CTL_IDLE);
    Branch_ctrl = 1'b1; #1;
    check("reset_branch_flush", {15'd0, reg_FD_flush}, 16'd1);
    Branch_ctrl = 1'b0;
    tick(); tick();
    rst_n = 1'b1; #1;
    check("post_reset_idle", ctl(), CTL_IDLE);

    // ALU x5 then read x5 on rs1; then a third op sees MEM ALU x5 and EX ALU x9
    set_id(0, 0, ALU, 5, 0, 0);
    tick();
    set_id(1, 1, ALU, 9, 5, 0);
    check("alu_ex_fwdA", ctl(), 16'b0000000_1100_01_00_0);
    tick();
    set_id(1, 1, ALU, 10, 5, 9);
    check("alu_mem_fwdA_ex_fwdB", ctl(), 16'b0000000_1100_10_01_0);
    tick();
    flush2();

    // LOAD x6 then ADD x7,x6,x0: one stall, then MEM load forward
    set_id(0, 0, LOAD, 6, 0, 0);
    tick();
    set_id(1, 1, ALU, 7, 6, 0);
    check("loaduse_stall", ctl(), CTL_STALL);
    tick();
    check("loaduse_after_stall", ctl(), 16'b0000000_1100_11_00_0);
    tick();
    flush2();

    // LOAD x12 then op reading x12 only via rs2 (rs1 matches but unused)
    set_id(0, 0, LOAD, 12, 0, 0);
    tick();
    set_id(0, 1, ALU, 13, 12, 12);
    check("loaduse_rs2_stall", ctl(), CTL_STALL);
    tick();
    check("loaduse_rs2_fwdB", ctl(), 16'b0000000_1100_00_11_0);
    tick();
    flush2();

    // LOAD x8 then SW x8 as rs2: no stall, store data forwarded next cycle
    set_id(0, 0, LOAD, 8, 0, 0);
    tick();
    set_id(1, 1, STORE, 0, 2, 8);
    check("store_no_stall", ctl(), CTL_IDLE);
    tick();
    set_id(0, 0, NONE, 0, 0, 0);
    check("store_fwd_ls", ctl(), 16'b0000000_1100_00_00_1);
    tick();
    check("store_fwd_ls_clear", {15'd0, forward_ctrl_ls}, 16'd0);
    tick();

    // ALU writing x0, then reads of x0 never forward; LOAD x0 never stalls
    set_id(0, 0, ALU, 0, 1, 2);
    tick();
    set_id(1, 1, ALU, 3, 0, 0);
    check("x0_ex", ctl(), CTL_IDLE);
    tick();
    set_id(1, 1, LOAD, 0, 0, 0);
    check("x0_mem", ctl(), CTL_IDLE);
    tick();
    set_id(1, 1, ALU, 4, 0, 0);
    check("x0_load_no_stall", ctl(), CTL_IDLE);
    tick();
    flush2();

    // Branch during load-use stall is deferred one cycle
    set_id(0, 0, LOAD, 6, 0, 0);
    tick();
    set_id(1, 0, ALU, 7, 6, 0);
    Branch_ctrl = 1'b1; #1;
    check("branch_in_stall", ctl(), CTL_STALL);
    tick();
    check("branch_after_stall", {14'd0, PC_EN_IF, reg_FD_flush}, 16'd3);
    Branch_ctrl = 1'b0;
    tick();
    flush2();

    // Reset mid-stall clears the stall without a clock edge
    set_id(0, 0, LOAD, 6, 0, 0);
    tick();
    set_id(1, 0, ALU, 7, 6, 0);
    check("pre_reset_stall", ctl(), CTL_STALL);
    rst_n = 1'b0; #1;
    check("reset_mid_stall", ctl(), CTL_IDLE);
    check("reset_ex_zero", {4'd0, dut.ex_q}, 16'd0);
    tick();
    rst_n = 1'b1; #1;
    check("release_ex_zero", {4'd0, dut.ex_q}, 16'd0);
    check("release_mem_zero", {4'd0, dut.mem_q}, 16'd0);
    check("release_idle", ctl(), CTL_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
